// File: rtl/rat_int_ctrl.sv
// Prioritising interrupt controller for the RAT MCU INT_CU input: edge-detects, latches, masks
// and sequences up to 8 sources. Optional input synchroniser: define INT_CTRL_SYNC_EN.
module rat_int_ctrl #(
  parameter int         N_SRC       = 8,
  parameter int         HOLD_CYCLES = 2,
  parameter logic [7:0] MASK_ID     = 8'hE0,
  parameter logic [7:0] PEND_ID     = 8'hE1,
  parameter logic [7:0] ACK_ID      = 8'hE2,
  parameter logic [7:0] VEC_ID      = 8'hE3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output logic             INT_CU,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, GAP} state_t;

  state_t           state;
  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_v;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] out_n;
  logic [2:0]       vec;
  logic [3:0]       hold_cnt;
  logic             wr_mask;
  logic             wr_ack;
  logic             ack_hit;

`ifdef INT_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IRQ_IN;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = IRQ_IN;
`endif

  // Lowest set index wins.
  function automatic logic [2:0] first_set(input logic [N_SRC-1:0] v);
    first_set = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) first_set = 3'(i);
    end
  endfunction

  assign edge_v    = irq_s & ~irq_prev;
  assign elig      = pend & mask;
  assign out_n     = OUT_PORT[N_SRC-1:0];
  assign wr_mask   = IO_STRB && (PORT_ID == MASK_ID);
  assign wr_ack    = IO_STRB && (PORT_ID == ACK_ID);
  assign ack_hit   = wr_ack && OUT_PORT[vec];
  assign state_dbg = state;

  // A fresh edge re-sets a bit even when the same write clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_prev <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      irq_prev <= irq_s;
      if (wr_mask) mask <= out_n;
      if (wr_ack) pend <= (pend & ~out_n) | edge_v;
      else        pend <= pend | edge_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      INT_CU   <= 1'b0;
      vec      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            state    <= REQ;
            vec      <= first_set(elig);
            hold_cnt <= 4'(HOLD_CYCLES);
            INT_CU   <= 1'b1;
          end
        end
        REQ: begin
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) begin
            state  <= SERVICE;
            INT_CU <= 1'b0;
          end
        end
        SERVICE: begin
          if (ack_hit) state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          INT_CU <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    RD_DATA = '0;
    RD_HIT  = 1'b0;
    case (PORT_ID)
      MASK_ID: begin
        RD_HIT               = 1'b1;
        RD_DATA[N_SRC-1:0]   = mask;
      end
      PEND_ID: begin
        RD_HIT               = 1'b1;
        RD_DATA[N_SRC-1:0]   = pend;
      end
      VEC_ID: begin
        RD_HIT               = 1'b1;
        RD_DATA[2:0]         = vec;
      end
      default: begin
        RD_HIT  = 1'b0;
        RD_DATA = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Bench for rat_int_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_rat_int_ctrl;
  localparam int HOLD = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] IRQ_IN = '0;
  logic [7:0] PORT_ID = '0;
  logic [7:0] OUT_PORT = '0;
  logic       IO_STRB = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_HIT;
  logic       INT_CU;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // clock/reset
  always #5 CLK = ~CLK;

  rat_int_ctrl dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT), .INT_CU(INT_CU), .state_dbg(state_dbg)
  );

  // reference model: registers plus a request countdown / await-ack / gap sequencer
  logic [7:0] m_prev = '0, m_s1 = '0, m_s2 = '0, m_pend = '0, m_mask = '0;
  int         m_vec = 0;
  int         m_hold_left = 0;
  bit         m_wait = 0, m_gap = 0;
  logic       m_int = 1'b0;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function void model_clock();
    logic [7:0] src, edge_v, elig;
`ifdef INT_CTRL_SYNC_EN
    src = m_s2;
`else
    src = IRQ_IN;
`endif
    edge_v = src & ~m_prev;
    elig   = m_pend & m_mask;
    if (RESET) begin
      m_prev = '0; m_s1 = '0; m_s2 = '0; m_pend = '0; m_mask = '0;
      m_vec = 0; m_hold_left = 0; m_wait = 0; m_gap = 0;
    end else begin
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_wait = 1;
      end else if (m_wait) begin
        if (IO_STRB && PORT_ID == 8'hE2 && OUT_PORT[m_vec]) begin
          m_wait = 0;
          m_gap  = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (elig != 0) begin
        m_vec       = lowest(elig);
        m_hold_left = HOLD;
      end
      if (IO_STRB && PORT_ID == 8'hE0) m_mask = OUT_PORT;
      if (IO_STRB && PORT_ID == 8'hE2) m_pend = (m_pend & ~OUT_PORT) | edge_v;
      else                             m_pend = m_pend | edge_v;
      m_prev = src;
      m_s2   = m_s1;
      m_s1   = IRQ_IN;
    end
    m_int = (m_hold_left > 0);
  endfunction

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reads();
    logic [7:0] ed;
    logic       eh;
    ed = '0;
    eh = 1'b0;
    case (PORT_ID)
      8'hE0: begin eh = 1'b1; ed = m_mask; end
      8'hE1: begin eh = 1'b1; ed = m_pend; end
      8'hE3: begin eh = 1'b1; ed = 8'(m_vec); end
      default: begin eh = 1'b0; ed = '0; end
    endcase
    #1;
    check_eq("rd_hit", 32'(RD_HIT), 32'(eh));
    check_eq("rd_data", 32'(RD_DATA), 32'(ed));
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic [7:0] irq, input logic [7:0] port,
                       input logic [7:0] outv, input logic strb);
    RESET    = r;
    IRQ_IN   = irq;
    PORT_ID  = port;
    OUT_PORT = outv;
    IO_STRB  = strb;
    check_reads();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_clock();
    #1;
    check_eq("int_cu", 32'(INT_CU), 32'(m_int));
  endtask

  task automatic cyc(input logic r, input logic [7:0] irq, input logic [7:0] port,
                     input logic [7:0] outv, input logic strb);
    drive(r, irq, port, outv, strb);
    tick();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic sync_wait();
`ifdef INT_CTRL_SYNC_EN
    repeat (2) idle();
`endif
  endtask

  task automatic peek(input logic [7:0] port, input string tag, input logic [7:0] exp_d,
                      input logic exp_h);
    logic [7:0] saved;
    saved   = PORT_ID;
    PORT_ID = port;
    #1;
    check_eq({tag, "_data"}, 32'(RD_DATA), 32'(exp_d));
    check_eq({tag, "_hit"}, 32'(RD_HIT), 32'(exp_h));
    PORT_ID = saved;
  endtask

  logic [7:0] irq_r;
  logic [7:0] port_r;
  logic [7:0] out_r;

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    peek(8'hE0, "rst_mask", 8'h00, 1);
    peek(8'hE1, "rst_pend", 8'h00, 1);
    peek(8'hE3, "rst_vec", 8'h00, 1);
    check_eq("rst_int", 32'(INT_CU), 0);

    // single source
    cyc(0, 8'h00, 8'hE0, 8'h01, 1);
    cyc(0, 8'h01, 8'h00, 8'h00, 0);
    sync_wait();
    peek(8'hE1, "t1_pend", 8'h01, 1);
    check_eq("t1_int_n1", 32'(INT_CU), 0);
    idle(); check_eq("t1_int_n2", 32'(INT_CU), 1);
    idle(); check_eq("t1_int_n3", 32'(INT_CU), 1);
    idle(); check_eq("t1_int_n4", 32'(INT_CU), 0);
    peek(8'hE3, "t1_vec", 8'h00, 1);
    cyc(0, 8'h00, 8'hE2, 8'h01, 1);
    idle();
    peek(8'hE1, "t1_pend_ack", 8'h00, 1);
    idle();

    // priority
    cyc(0, 8'h00, 8'hE0, 8'hFF, 1);
    cyc(0, 8'h24, 8'h00, 8'h00, 0);
    sync_wait();
    idle(); idle(); idle();
    peek(8'hE3, "pri_vec_a", 8'h02, 1);
    cyc(0, 8'h00, 8'hE2, 8'h04, 1);
    idle();
    idle(); check_eq("pri_int_b", 32'(INT_CU), 1);
    peek(8'hE3, "pri_vec_b", 8'h05, 1);
    idle(); idle();
    cyc(0, 8'h00, 8'hE2, 8'h20, 1);
    idle(); idle();

    // masked source
    cyc(0, 8'h00, 8'hE0, 8'h00, 1);
    cyc(0, 8'h08, 8'h00, 8'h00, 0);
    sync_wait();
    idle();
    peek(8'hE1, "msk_pend", 8'h08, 1);
    check_eq("msk_int_a", 32'(INT_CU), 0);
    idle(); check_eq("msk_int_b", 32'(INT_CU), 0);
    cyc(0, 8'h00, 8'hE0, 8'h08, 1);
    check_eq("msk_int_w1", 32'(INT_CU), 0);
    idle(); check_eq("msk_int_w2", 32'(INT_CU), 1);
    idle(); idle();
    cyc(0, 8'h00, 8'hE2, 8'h08, 1);
    idle(); idle();

    // set wins over clear
    cyc(0, 8'h10, 8'h00, 8'h00, 0);
    sync_wait();
    idle();
    peek(8'hE1, "svc_pend_a", 8'h10, 1);
    cyc(0, 8'h10, 8'hE2, 8'h10, 1);
    sync_wait();
    peek(8'hE1, "svc_pend_b", 8'h10, 1);
    cyc(0, 8'h00, 8'hE2, 8'h10, 1);
    idle();

    // reset mid-request
    cyc(0, 8'h00, 8'hE0, 8'hFF, 1);
    cyc(0, 8'h02, 8'h00, 8'h00, 0);
    sync_wait();
    idle(); idle();
    check_eq("rmr_int_a", 32'(INT_CU), 1);
    cyc(1, 8'h00, 8'h00, 8'h00, 0);
    check_eq("rmr_int_b", 32'(INT_CU), 0);
    peek(8'hE0, "rmr_mask", 8'h00, 1);
    peek(8'hE1, "rmr_pend", 8'h00, 1);
    peek(8'hE3, "rmr_vec", 8'h00, 1);

    // decode
    cyc(0, 8'h00, 8'hE0, 8'hA5, 1);
    peek(8'hE0, "dec_mask", 8'hA5, 1);
    peek(8'hE2, "dec_ack", 8'h00, 0);
    peek(8'h55, "dec_other", 8'h00, 0);

    // random traffic
    irq_r = '0;
    for (int n = 0; n < 4000; n++) begin
      irq_r ^= 8'($urandom & $urandom & $urandom);
      case ($urandom_range(0, 4))
        0: port_r = 8'hE0;
        1: port_r = 8'hE1;
        2: port_r = 8'hE2;
        3: port_r = 8'hE3;
        default: port_r = 8'($urandom);
      endcase
      if (port_r == 8'hE2 && $urandom_range(0, 1) == 1)
        out_r = 8'(1 << m_vec) | 8'($urandom & $urandom);
      else
        out_r = 8'($urandom);
      cyc(($urandom_range(0, 299) == 0), irq_r, port_r, out_r, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
